// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between sync_fifo_param and its producer/consumer.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  rinc;
    logic                  errClr;
    logic [DATA_WIDTH-1:0] readData;
    logic                  readValid;
    logic                  full;
    logic                  empty;
    logic                  almostFull;
    logic                  almostEmpty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, writeData, rinc, errClr,
        input  readData, readValid, full, empty, almostFull, almostEmpty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, writeData, rinc, errClr,
        output readData, readValid, full, empty, almostFull, almostEmpty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_AE    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  full, empty, wacc, racc;
    logic [ADDR_WIDTH-1:0] waddr, raddr;

    // Status is decoded from the registered count only, so it moves on clock edges.
    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);
    assign wacc  = bus.winc & ~full;
    assign racc  = bus.rinc & ~empty;
    assign waddr = wptr_q[ADDR_WIDTH-1:0];
    assign raddr = rptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wacc) wptr_d = wptr_q + CNT_ONE;
        if (racc) rptr_d = rptr_q + CNT_ONE;
        if (wacc && !racc)      count_d = count_q + CNT_ONE;
        else if (racc && !wacc) count_d = count_q - CNT_ONE;
        // A fresh error in the same cycle as errClr keeps the flag set.
        ovf_d = (ovf_q & ~bus.errClr) | (bus.winc & full);
        udf_d = (udf_q & ~bus.errClr) | (bus.rinc & empty);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: storage has no reset; empty gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (wacc) mem_q[waddr] <= bus.writeData;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.readData  = mem_q[raddr];
    assign bus.readValid = ~empty;
`else
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= racc;
            if (racc) rdata_q <= mem_q[raddr];
        end
    end

    assign bus.readData  = rdata_q;
    assign bus.readValid = rvalid_q;
`endif

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostFull  = (count_q >= CNT_AF);
    assign bus.almostEmpty = (count_q <= CNT_AE);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (registered read port build): queue model plus directed vectors.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: the FIFO is a queue; status is derived from its size.
    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic model_edge();
        bit was_full;
        bit was_empty;
        if (rst) begin
            model_reset();
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_rvalid  = 1'b0;
        if (bus.rinc && !was_empty) begin
            m_rdata  = mq.pop_front();
            m_rvalid = 1'b1;
        end
        if (bus.winc && !was_full) mq.push_back(bus.writeData);
        if (bus.errClr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (bus.winc && was_full) m_ovf = 1'b1;
        if (bus.rinc && was_empty) m_udf = 1'b1;
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bus.winc      = w;
        bus.writeData = d;
        bus.rinc      = r;
        bus.errClr    = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("count",       32'(bus.count),       32'(mq.size()));
            check("full",        32'(bus.full),        32'(mq.size() == DEPTH));
            check("empty",       32'(bus.empty),       32'(mq.size() == 0));
            check("almostFull",  32'(bus.almostFull),  32'(mq.size() >= AF));
            check("almostEmpty", 32'(bus.almostEmpty), 32'(mq.size() <= AE));
            check("overflow",    32'(bus.overflow),    32'(m_ovf));
            check("underflow",   32'(bus.underflow),   32'(m_udf));
            check("readValid",   32'(bus.readValid),   32'(m_rvalid));
            check("readData",    32'(bus.readData),    32'(m_rdata));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"},  32'(bus.empty),       32'd1);
        check({tag, "_full"},   32'(bus.full),        32'd0);
        check({tag, "_count"},  32'(bus.count),       32'd0);
        check({tag, "_ae"},     32'(bus.almostEmpty), 32'd1);
        check({tag, "_af"},     32'(bus.almostFull),  32'd0);
        check({tag, "_rvalid"}, 32'(bus.readValid),   32'd0);
        check({tag, "_rdata"},  32'(bus.readData),    32'h00);
        check({tag, "_ovf"},    32'(bus.overflow),    32'd0);
        check({tag, "_udf"},    32'(bus.underflow),   32'd0);
    endtask

    initial begin
        bus.winc      = 1'b0;
        bus.writeData = '0;
        bus.rinc      = 1'b0;
        bus.errClr    = 1'b0;
        model_reset();

        // 1. Reset values
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst    = 1'b0;
        chk_en = 1'b1;

        // 2. Fill with 0xA0..0xA7, thresholds, overflow
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            if (i == 1) check("ae_after2", 32'(bus.almostEmpty), 32'd1);
            if (i == 2) check("ae_after3", 32'(bus.almostEmpty), 32'd0);
            if (i == 4) check("af_after5", 32'(bus.almostFull), 32'd0);
            if (i == 5) check("af_after6", 32'(bus.almostFull), 32'd1);
        end
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd8);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count),    32'd8);

        // 3. Drain, underflow, error clear
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_data",  32'(bus.readData),  32'(8'hA0 + i));
            check("drain_valid", 32'(bus.readValid), 32'd1);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_set",    32'(bus.underflow), 32'd1);
        check("udf_rvalid", 32'(bus.readValid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow),  32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus.overflow),  32'd0);
        check("clr_udf", 32'(bus.underflow), 32'd0);

        // 4. Address wrap-around
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("wrap_data", 32'(bus.readData), 32'(8'h10 + i));
        end
        check("wrap_count", 32'(bus.count), 32'd0);

        // 5. Simultaneous read and write
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h24, 1'b1, 1'b0);
        check("rw4_count", 32'(bus.count),    32'd4);
        check("rw4_data",  32'(bus.readData), 32'h20);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("rw4_order", 32'(bus.readData), 32'(8'h21 + i));
        end
        step(1'b1, 8'h30, 1'b1, 1'b0);
        check("rw0_count",  32'(bus.count),     32'd1);
        check("rw0_udf",    32'(bus.underflow), 32'd1);
        check("rw0_rvalid", 32'(bus.readValid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        check("rw8_pre", 32'(bus.count), 32'd8);
        step(1'b1, 8'h40, 1'b1, 1'b0);
        check("rw8_count", 32'(bus.count),    32'd7);
        check("rw8_ovf",   32'(bus.overflow), 32'd1);
        check("rw8_data",  32'(bus.readData), 32'h30);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd5);

        // 6. Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check_reset_values("mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_rst_data",  32'(bus.readData),  32'h3C);
        check("post_rst_valid", 32'(bus.readValid), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO for datapaths where producer and consumer share one clock, so no pointer synchronisation is needed.
- Adds to the existing 8x8 asynchronous FIFO: configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a registered read port with a valid strobe.
- Sits between pipeline stages in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of writeData/readData in bits
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH
AF_LEVEL, 6, almostFull asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almostEmpty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
winc  input  1  write request
writeData  input  DATA_WIDTH  write data
rinc  input  1  read (pop) request
errClr  input  1  synchronous clear of the sticky overflow/underflow flags
readData  output  DATA_WIDTH  read data
readValid  output  1  readData holds a newly popped word
full  output  1  count == DEPTH
empty  output  1  count == 0
almostFull  output  1  count >= AF_LEVEL
almostEmpty  output  1  count <= AE_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Pointers: wptr and rptr are ADDR_WIDTH+1-bit binary registers that wrap modulo 2*DEPTH. Memory address is ptr[ADDR_WIDTH-1:0].
- count = wptr - rptr, held as a register. All status outputs are decoded from the registered count, so they change only on clock edges.
- Write acceptance: wacc = winc & !full.
  - On wacc: mem[waddr] <= writeData and wptr increments.
  - Simultaneous rinc never unblocks a write when full.
- Read acceptance: racc = rinc & !empty.
  - On racc: rptr increments.
  - Simultaneous winc never unblocks a read when empty.
- count update: +1 on wacc only; -1 on racc only; unchanged when both or neither.
- Read port (default mode):
  - On racc: readData <= mem[raddr] and readValid <= 1 at the same edge, so data appears one cycle after rinc.
  - Otherwise readValid <= 0 and readData holds its last value.
- Error flags:
  - overflow sets on winc & full; underflow sets on rinc & empty.
  - Both stay set until errClr is sampled high. If errClr and a new error occur in the same cycle, set wins.
  - Rejected requests change no pointer, count or memory.
- Reset (asynchronous, effective immediately, including mid-operation):
  - wptr = rptr = count = 0.
  - empty = 1, full = 0, almostEmpty = 1, almostFull = 0.
  - readData = 0, readValid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset; stale data is never visible because empty gates all reads.
- Latency: a write becomes poppable one cycle after its edge (empty deasserts on the next edge).

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - readData = mem[raddr] combinationally whenever !empty.
  - readValid = !empty.
  - rinc acknowledges and pops the displayed word; the next word appears at the following edge.
  - The readData reset value is don't-care while empty.
  - All counting, status and error rules are unchanged.
- Undefined: registered read port as described in Behaviour.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2.
1. Reset asserted -> empty=1, full=0, count=0, almostEmpty=1, almostFull=0, readValid=0, readData=0x00, overflow=0, underflow=0.
2. Write 0xA0..0xA7 on 8 consecutive cycles -> almostFull rises after the 6th edge and almostEmpty falls after the 3rd; after the 8th edge full=1, count=8. A 9th winc -> overflow=1, count stays 8, later reads still return 0xA0 first.
3. From full, rinc for 8 cycles -> readData 0xA0..0xA7, each with readValid=1 one cycle after its rinc; empty=1 after the last. A further rinc -> underflow=1, readValid=0. errClr=1 for one cycle -> overflow=0, underflow=0.
4. Wrap-around: write 5, read 5, write 6 (0x10..0x15), read 6 -> output order 0x10..0x15 intact across the address wrap; count returns to 0.
5. Simultaneous events:
   - winc&rinc at count=4 -> count stays 4 and data order is preserved.
   - winc&rinc at empty -> count=1, underflow=1.
   - winc&rinc at full -> count=7, overflow=1.
6. Reset mid-operation: at count=5, assert rst between clock edges -> all outputs take reset values before the next edge. After release, write 0x3C then read -> readData=0x3C.
